operand_forward_stage: RTL and testbench
========================================

OPERAND_FORWARD_STAGE -- requirements
Module: operand_forward_stage

Interface
REQ-001 Parameter: NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on reset, flush and bubble insertion.
REQ-002 Single clock and reset: clock and reset are synchronous, active-high; no other clock or async path exists.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_inst, id_pc, id_imm  in  32 each  decoded instruction, its PC, sign-extended immediate.
REQ-007 id_rs1_data, id_rs2_data  in  32 each  register-file read data.
REQ-008 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-009 id_alu_src  in  1  1 = operand 2 is immediate; id_op1_pc  in  1  1 = operand 1 is PC.
REQ-010 exmem_reg_write  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM producer.
REQ-011 memwb_reg_write  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB producer.
REQ-012 stall  in  1  hold EX contents; flush  in  1  kill EX contents.
REQ-013 ex_valid  out  1; ex_inst, ex_pc  out  32; ex_rd  out  5  registered EX-stage state.
REQ-014 alu_in_1, alu_in_2  out  32  ALU operands; ex_store_data  out  32  forwarded rs2 for stores.
REQ-015 fwd_sel_1, fwd_sel_2  out  2  forwarding source per operand (0 regfile, 1 MEM/WB, 2 EX/MEM).

Function
REQ-016 Registered state: valid, inst, pc, imm, rs1, rs2, rd, rs1_q, rs2_q, alu_src, op1_pc; updated only on rising clk.
REQ-017 Priority per edge: reset > flush > stall > load.
REQ-018 Load (no stall, no flush): capture all id_* fields; ex_valid <= id_valid; if id_valid=0, inst <= NOP_INST and rd <= 0.
REQ-019 Latency: ID fields presented in cycle N appear on ex_* / ALU operands in cycle N+1.
REQ-020 Flush: ex_valid <= 0, ex_inst <= NOP_INST, ex_rd <= 0, rs1/rs2 <= 0; other fields are don't-care.
REQ-021 Flush and stall together: flush wins; the bubble is taken, ID contents are not captured.
REQ-022 Forward match on operand k: producer reg_write=1, producer rd == registered rs_k, rs_k != 0.
REQ-023 Source select: EX/MEM match -> 2; else MEM/WB match -> 1; else 0 (rs_k_q); combinational, same cycle.
REQ-024 Register x0 is never forwarded; a resolved operand for rs_k=0 equals rs_k_q, which is 0 from the register file.
REQ-025 fwd_rs_k = value selected by fwd_sel_k; ex_store_data = fwd_rs2.
REQ-026 alu_in_1 = ex_pc if op1_pc else fwd_rs1; alu_in_2 = imm if alu_src else fwd_rs2.
REQ-027 Stall: all fields hold, except rs1_q <= fwd_rs1 and rs2_q <= fwd_rs2 every stalled cycle, so operands survive producer retirement.
REQ-028 Multi-cycle stall: operands stay stable across the stall even if producers change rd or deassert reg_write.
REQ-029 Forwarding muxes operate whenever ex_valid=0 too; fwd_sel outputs stay defined, with no X propagation from held data.
REQ-030 Arithmetic: none; all paths are 32-bit pass-through selection; no width extension inside the block.

Reset
REQ-031 While reset=1 at a rising edge: ex_valid=0, ex_inst=NOP_INST, ex_pc=0, ex_rd=0, imm=0, rs1/rs2=0, rs1_q/rs2_q=0, alu_src=0, op1_pc=0.
REQ-032 Resulting outputs after reset: alu_in_1=0, alu_in_2=0, ex_store_data=0, fwd_sel_1=fwd_sel_2=0 (given no forward match on x0).
REQ-033 Reset asserted mid-stall or with flush discards held state; the first load after reset deasserts behaves as REQ-018.

Verification
REQ-034 Reset -> ex_valid=0, ex_inst=32'h00000013, alu_in_1=alu_in_2=0.
REQ-035 Load add x3,x1,x2 (rs1_data=5, rs2_data=7), no matches -> next cycle alu_in_1=5, alu_in_2=7, fwd_sel=0/0.
REQ-036 EX rs1=x1; exmem rd=x1, result=0x10; memwb rd=x1, result=0x20 -> alu_in_1=0x10, fwd_sel_1=2.
REQ-037 EX rs2=x0, memwb_reg_write=1, memwb_rd=0, result=0xFFFF -> fwd_sel_2=0, ex_store_data=0.
REQ-038 Stall 3 cycles with memwb forward 0x55 on rs1, producer drops after cycle 1 -> alu_in_1 stays 0x55 all 3 cycles.
REQ-039 stall=1 and flush=1 same edge with id_valid=1 -> ex_valid=0, ex_inst=NOP_INST, ex_rd=0.

Source files
------------

// File: rtl/operand_forward_stage.sv
// Operand forwarding stage: ID/EX pipeline register plus the operand
// bypass network. EX-stage state is registered from the ID fields; ALU
// operands are resolved combinationally from the registered register-file
// data or from the EX/MEM and MEM/WB producers.
module operand_forward_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_alu_src,
  input  logic        id_op1_pc,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [31:0] ex_store_data,
  output logic [1:0]  fwd_sel_1,
  output logic [1:0]  fwd_sel_2
);

  // Registered EX-stage state
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs1_idx_q, rs1_idx_d;
  logic [4:0]  rs2_idx_q, rs2_idx_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rs1_val_q, rs1_val_d;
  logic [31:0] rs2_val_q, rs2_val_d;
  logic        alu_src_q, alu_src_d;
  logic        op1_pc_q, op1_pc_d;

  // Resolved (forwarded) register operands
  logic [1:0]  sel_1, sel_2;
  logic [31:0] fwd_rs1, fwd_rs2;

  // Youngest producer wins; x0 is hard-wired to zero and never bypassed.
  function automatic logic [1:0] pick_src(input logic [4:0] rs);
    logic [1:0] src;
    src = 2'd0;
    if (rs != 5'd0) begin
      if (exmem_reg_write && (exmem_rd == rs)) begin
        src = 2'd2;
      end else if (memwb_reg_write && (memwb_rd == rs)) begin
        src = 2'd1;
      end
    end
    return src;
  endfunction

  // Bypass selection for both operands, active regardless of ex_valid
  always_comb begin
    sel_1 = pick_src(rs1_idx_q);
    sel_2 = pick_src(rs2_idx_q);
    case (sel_1)
      2'd2:    fwd_rs1 = exmem_result;
      2'd1:    fwd_rs1 = memwb_result;
      default: fwd_rs1 = rs1_val_q;
    endcase
    case (sel_2)
      2'd2:    fwd_rs2 = exmem_result;
      2'd1:    fwd_rs2 = memwb_result;
      default: fwd_rs2 = rs2_val_q;
    endcase
  end

  // Next-state: flush beats stall beats load; reset is applied in the flop block
  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    rd_d      = rd_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    alu_src_d = alu_src_q;
    op1_pc_d  = op1_pc_q;
    if (flush) begin
      // Bubble: data fields are don't-care, zeroed to keep them clean
      valid_d   = 1'b0;
      inst_d    = NOP_INST;
      rd_d      = 5'd0;
      rs1_idx_d = 5'd0;
      rs2_idx_d = 5'd0;
      rs1_val_d = 32'd0;
      rs2_val_d = 32'd0;
    end else if (stall) begin
      // Latch the bypassed values so operands survive producer retirement
      rs1_val_d = fwd_rs1;
      rs2_val_d = fwd_rs2;
    end else begin
      valid_d   = id_valid;
      inst_d    = id_valid ? id_inst : NOP_INST;
      rd_d      = id_valid ? id_rd : 5'd0;
      pc_d      = id_pc;
      imm_d     = id_imm;
      rs1_idx_d = id_rs1;
      rs2_idx_d = id_rs2;
      rs1_val_d = id_rs1_data;
      rs2_val_d = id_rs2_data;
      alu_src_d = id_alu_src;
      op1_pc_d  = id_op1_pc;
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      pc_q      <= 32'd0;
      imm_q     <= 32'd0;
      rs1_idx_q <= 5'd0;
      rs2_idx_q <= 5'd0;
      rd_q      <= 5'd0;
      rs1_val_q <= 32'd0;
      rs2_val_q <= 32'd0;
      alu_src_q <= 1'b0;
      op1_pc_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      rd_q      <= rd_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      alu_src_q <= alu_src_d;
      op1_pc_q  <= op1_pc_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_inst       = inst_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign fwd_sel_1     = sel_1;
  assign fwd_sel_2     = sel_2;
  assign ex_store_data = fwd_rs2;
  assign alu_in_1      = op1_pc_q ? pc_q : fwd_rs1;
  assign alu_in_2      = alu_src_q ? imm_q : fwd_rs2;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Self-checking bench for operand_forward_stage: a behavioural model
// predicts each cycle's outputs into a scoreboard queue when stimulus is
// driven; entries are popped and compared once the DUT has clocked.
module tb_operand_forward_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_inst = 32'd0, id_pc = 32'd0, id_imm = 32'd0;
  logic [31:0] id_rs1_data = 32'd0, id_rs2_data = 32'd0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic        id_alu_src = 1'b0, id_op1_pc = 1'b0;
  logic        exmem_reg_write = 1'b0, memwb_reg_write = 1'b0;
  logic [4:0]  exmem_rd = 5'd0, memwb_rd = 5'd0;
  logic [31:0] exmem_result = 32'd0, memwb_result = 32'd0;
  logic        stall = 1'b0, flush = 1'b0;

  logic        ex_valid;
  logic [31:0] ex_inst, ex_pc;
  logic [4:0]  ex_rd;
  logic [31:0] alu_in_1, alu_in_2, ex_store_data;
  logic [1:0]  fwd_sel_1, fwd_sel_2;

  operand_forward_stage #(.NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_op1_pc(id_op1_pc),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .ex_store_data(ex_store_data),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2)
  );

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] a1, a2, sd;
    logic [1:0]  s1, s2;
    logic        known;
  } exp_t;

  exp_t sb_q[$];

  // Reference model of the EX-stage register
  logic        m_valid = 1'b0, m_alu_src = 1'b0, m_op1_pc = 1'b0, m_known = 1'b0;
  logic [31:0] m_inst = NOP, m_pc = 32'd0, m_imm = 32'd0, m_v1 = 32'd0, m_v2 = 32'd0;
  logic [4:0]  m_rs1 = 5'd0, m_rs2 = 5'd0, m_rd = 5'd0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_sel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (exmem_reg_write && exmem_rd == rs) return 2'd2;
    if (memwb_reg_write && memwb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] rs, input logic [31:0] held);
    logic [1:0] s;
    s = m_sel(rs);
    if (s == 2'd2) return exmem_result;
    if (s == 2'd1) return memwb_result;
    return held;
  endfunction

  // One clock: predict, push, wait for the edge, pop and compare
  task automatic cycle(input string tag);
    exp_t e;
    logic [31:0] f1, f2;
    f1 = m_val(m_rs1, m_v1);
    f2 = m_val(m_rs2, m_v2);
    if (reset) begin
      m_valid = 1'b0; m_inst = NOP; m_pc = 32'd0; m_imm = 32'd0; m_rd = 5'd0;
      m_rs1 = 5'd0; m_rs2 = 5'd0; m_v1 = 32'd0; m_v2 = 32'd0;
      m_alu_src = 1'b0; m_op1_pc = 1'b0; m_known = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0; m_inst = NOP; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0;
      m_known = 1'b0;
    end else if (stall) begin
      m_v1 = f1;
      m_v2 = f2;
    end else begin
      m_valid = id_valid;
      m_inst = id_valid ? id_inst : NOP;
      m_rd = id_valid ? id_rd : 5'd0;
      m_pc = id_pc; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_v1 = id_rs1_data; m_v2 = id_rs2_data;
      m_alu_src = id_alu_src; m_op1_pc = id_op1_pc; m_known = 1'b1;
    end
    e.v = m_valid; e.inst = m_inst; e.rd = m_rd; e.pc = m_pc;
    e.s1 = m_sel(m_rs1); e.s2 = m_sel(m_rs2);
    e.sd = m_val(m_rs2, m_v2);
    e.a1 = m_op1_pc ? m_pc : m_val(m_rs1, m_v1);
    e.a2 = m_alu_src ? m_imm : e.sd;
    e.known = m_known;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_val({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e.v});
    check_val({tag, ".ex_inst"}, ex_inst, e.inst);
    check_val({tag, ".ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    check_val({tag, ".fwd_sel_1"}, {30'd0, fwd_sel_1}, {30'd0, e.s1});
    check_val({tag, ".fwd_sel_2"}, {30'd0, fwd_sel_2}, {30'd0, e.s2});
    if (e.known) begin
      check_val({tag, ".ex_pc"}, ex_pc, e.pc);
      check_val({tag, ".alu_in_1"}, alu_in_1, e.a1);
      check_val({tag, ".alu_in_2"}, alu_in_2, e.a2);
      check_val({tag, ".store_data"}, ex_store_data, e.sd);
    end
    $display("%0t %s v=%0d inst=%h rd=%0d a1=%h a2=%h sd=%h sel=%0d/%0d",
             $time, tag, ex_valid, ex_inst, ex_rd, alu_in_1, alu_in_2,
             ex_store_data, fwd_sel_1, fwd_sel_2);
  endtask

  task automatic set_id(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic asrc, input logic opc);
    id_valid = v; id_inst = inst; id_pc = pc; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2;
    id_alu_src = asrc; id_op1_pc = opc;
  endtask

  task automatic set_prod(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    cycle("reset0");
    cycle("reset1");
    check_val("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_val("rst.ex_inst", ex_inst, 32'h00000013);
    check_val("rst.alu_in_1", alu_in_1, 32'd0);
    check_val("rst.alu_in_2", alu_in_2, 32'd0);
    reset = 1'b0;

    // add x3,x1,x2 with no producers
    set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 32'h002081B3, 32'h40, 32'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0);
    cycle("add");
    check_val("add.alu_in_1", alu_in_1, 32'd5);
    check_val("add.alu_in_2", alu_in_2, 32'd7);
    check_val("add.fwd_sel_1", {30'd0, fwd_sel_1}, 32'd0);
    check_val("add.ex_rd", {27'd0, ex_rd}, 32'd3);

    // Both producers write x1: EX/MEM has priority
    set_prod(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20);
    cycle("fwd_prio");
    check_val("prio.alu_in_1", alu_in_1, 32'h10);
    check_val("prio.fwd_sel_1", {30'd0, fwd_sel_1}, 32'd2);

    // Only MEM/WB matches
    set_prod(1'b1, 5'd9, 32'h10, 1'b1, 5'd1, 32'h20);
    cycle("fwd_memwb");
    check_val("memwb.alu_in_1", alu_in_1, 32'h20);
    check_val("memwb.fwd_sel_1", {30'd0, fwd_sel_1}, 32'd1);

    // x0 is never forwarded
    set_prod(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    set_id(1'b1, 32'h00102023, 32'h44, 32'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 1'b0, 1'b0);
    cycle("x0");
    check_val("x0.fwd_sel_2", {30'd0, fwd_sel_2}, 32'd0);
    check_val("x0.store_data", ex_store_data, 32'd0);

    // PC and immediate operand selection
    set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 32'hFF010117, 32'h100, 32'hFFFFFFF0, 5'd2, 5'd3, 5'd2, 32'd11, 32'd22, 1'b1, 1'b1);
    cycle("pc_imm");
    check_val("pcimm.alu_in_1", alu_in_1, 32'h100);
    check_val("pcimm.alu_in_2", alu_in_2, 32'hFFFFFFF0);
    check_val("pcimm.store_data", ex_store_data, 32'd22);

    // Multi-cycle stall holding a MEM/WB forward after the producer retires
    set_id(1'b1, 32'h00028333, 32'h200, 32'd0, 5'd5, 5'd0, 5'd6, 32'h11, 32'd0, 1'b0, 1'b0);
    cycle("ld_stall");
    check_val("ldst.alu_in_1", alu_in_1, 32'h11);
    stall = 1'b1;
    set_prod(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
    set_id(1'b1, 32'hDEADBEEF, 32'h300, 32'd1, 5'd7, 5'd7, 5'd7, 32'hBAD, 32'hBAD, 1'b1, 1'b1);
    cycle("stall1");
    check_val("stall1.alu_in_1", alu_in_1, 32'h55);
    set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle("stall2");
    check_val("stall2.alu_in_1", alu_in_1, 32'h55);
    set_prod(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    cycle("stall3");
    check_val("stall3.alu_in_1", alu_in_1, 32'h55);
    check_val("stall3.ex_pc", ex_pc, 32'h200);

    // Flush and stall together: flush wins
    flush = 1'b1;
    cycle("flush_stall");
    check_val("fs.ex_valid", {31'd0, ex_valid}, 32'd0);
    check_val("fs.ex_inst", ex_inst, 32'h00000013);
    check_val("fs.ex_rd", {27'd0, ex_rd}, 32'd0);
    flush = 1'b0;
    stall = 1'b0;

    // Invalid ID slot loads a bubble
    set_prod(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b0, 32'h12345678, 32'h400, 32'd3, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 1'b0, 1'b0);
    cycle("id_invalid");
    check_val("inv.ex_inst", ex_inst, 32'h00000013);
    check_val("inv.ex_rd", {27'd0, ex_rd}, 32'd0);

    // Reset during a stall discards held state, then a normal load
    set_id(1'b1, 32'h002081B3, 32'h500, 32'd0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 1'b0, 1'b0);
    cycle("pre_rst");
    stall = 1'b1;
    reset = 1'b1;
    cycle("rst_stall");
    check_val("rststall.alu_in_1", alu_in_1, 32'd0);
    check_val("rststall.ex_pc", ex_pc, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    cycle("post_rst");
    check_val("postrst.alu_in_1", alu_in_1, 32'd8);

    // Randomised traffic with a narrow register range to provoke matches
    for (int i = 0; i < 300; i++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      set_id(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, r1, r2,
             5'($urandom_range(0, 31)),
             (r1 == 5'd0) ? 32'd0 : $urandom, (r2 == 5'd0) ? 32'd0 : $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_prod(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      cycle("rnd");
    end

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
